set_mode_ctrl: RTL and testbench
================================

Name: set_mode_ctrl

Overview:
Edit-mode controller for the millennium clock. It sits between the raw user controls (set_mode, sel, set_select, inc_btn, dec_btn) and the time/date counter datapath. It synchronizes and debounces the buttons and decodes the field being edited. It issues single-cycle inc/dec strobes with hold-to-auto-repeat, gates the free-running counter, and drives the field-blink mask for the HEX display.

Parameters:
DEBOUNCE_TICKS, 2, consecutive equal tick samples required to accept a button level change
REPEAT_DELAY, 50, ticks from the first strobe to the first auto-repeat strobe (500 ms at a 10 ms tick)
REPEAT_RATE, 10, ticks between subsequent auto-repeat strobes
BLINK_TICKS, 25, ticks per blink half-period

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_10ms  in  1  one-clk-wide timebase pulse from the clock divider
set_mode  in  1  1 = edit mode, 0 = run
sel  in  1  0 = TIME fields, 1 = DATE fields
set_select  in  2  0 = SS/DD, 1 = MM/MONTH, 2 = HH/YEAR, 3 = no field
inc_btn  in  1  raw increment button, active-low
dec_btn  in  1  raw decrement button, active-low
run_en  out  1  1 = datapath counts seconds normally
inc_pulse  out  1  one-clk increment strobe for field_sel
dec_pulse  out  1  one-clk decrement strobe for field_sel
field_sel  out  3  0 SS, 1 MM, 2 HH, 3 DD, 4 MONTH, 5 YEAR, 7 none
blink_mask  out  6  bit i = 1 blanks field i on the display (same encoding as field_sel)

Behaviour:
- Reset values: run_en = 1, inc_pulse = 0, dec_pulse = 0, field_sel = 7, blink_mask = 0. All synchronizers, debounce state, counters and the FSM are cleared; debounced buttons read released.
- Synchronization: every control input passes through a 2-FF synchronizer. The buttons are inverted after synchronization, so internally 1 = pressed.
- Debounce:
  - The synced button is sampled on each tick_10ms.
  - The debounced level changes only after DEBOUNCE_TICKS consecutive tick samples at the new level.
  - A glitch shorter than that produces no change.
- Field decode (combinational from synced inputs):
  - field_sel = 7 when set_mode = 0 or set_select = 3.
  - Otherwise field_sel = set_select + 3*sel.
- run_en = ~set_mode_sync. This takes effect 2 clk after the set_mode pin changes.
- FSM states: IDLE, FIRST, DELAY, REPEAT, LOCK.
  - IDLE: on a debounced press of exactly one button with field_sel != 7, latch the direction and field, then go to FIRST.
  - FIRST: assert inc_pulse or dec_pulse for exactly one clk, clear the repeat counter, go to DELAY.
  - DELAY: count ticks. On reaching REPEAT_DELAY, emit one strobe and go to REPEAT.
  - REPEAT: emit one strobe every REPEAT_RATE ticks while the button stays held.
  - Release in DELAY or REPEAT returns to IDLE with no extra strobe.
- Strobe latency: the strobe is asserted in the clk immediately after the tick that accepts the debounced press.
- Both buttons debounced-pressed together, from any state: go to LOCK with no strobe. Remain in LOCK until both are released, then go to IDLE. A press of one button while the other is already held also enters LOCK.
- Abort conditions:
  - set_mode falls, field_sel changes, or field_sel = 7 while in FIRST/DELAY/REPEAT: go to LOCK, suppress any pending strobe, and require a full release before the next press is accepted.
  - A press while field_sel = 7 is ignored, and it stays ignored until released.
- inc_pulse and dec_pulse are never asserted in the same clk, and are never asserted while set_mode_sync = 0.
- Blink:
  - The phase bit toggles every BLINK_TICKS ticks while set_mode_sync = 1.
  - The phase bit is forced to 0 and its counter cleared while not in edit mode, and on every strobe, so the field stays visible while it is being adjusted.
  - blink_mask = one-hot(field_sel) when phase = 1 and field_sel != 7; otherwise 0.
- The tick counters saturate at their terminal values. Nothing wraps while idle.
- Reset asserted mid-hold: all outputs take their reset values immediately (asynchronous), with no strobe on reset release. A still-held button must be released and pressed again.

Test Plan:
- Reset, then set_mode = 0 and press inc for 20 ticks -> run_en = 1, no strobes, field_sel = 7, blink_mask = 0.
- set_mode = 1, sel = 0, set_select = 1, hold inc 95 ticks after acceptance -> field_sel = 1, run_en = 0 within 2 clk. inc_pulse occurs at ticks 0, 50, 60, 70, 80, 90 (6 pulses), each 1 clk wide, with no dec_pulse.
- sel = 1, set_select = 2, 1-tick glitch on dec then a clean 5-tick dec press -> glitch gives nothing. Exactly one dec_pulse, with field_sel = 5.
- Hold inc, then press dec at tick 30 -> LOCK and no further strobes. Release both, then a fresh inc press -> exactly one inc_pulse.
- Edit mode, set_select = 0, idle for 100 ticks -> blink_mask alternates 000000/000001 every 25 ticks. An inc press restarts the phase, so the mask stays 000000 for 25 ticks after the strobe.
- Hold inc in REPEAT, drop set_mode at tick 65 -> no strobe after the drop, run_en = 1 two clk later. Assert rst_n = 0 mid-hold in a second run -> all outputs reset immediately, and there is no strobe after release while inc is still held.

Source files
------------

// File: rtl/set_mode_ctrl_if.sv
// Control/status bundle between the user-control front end and the clock datapath.
interface set_mode_ctrl_if;
  logic       tick_10ms;
  logic       set_mode;
  logic       sel;
  logic [1:0] set_select;
  logic       inc_btn;
  logic       dec_btn;
  logic       run_en;
  logic       inc_pulse;
  logic       dec_pulse;
  logic [2:0] field_sel;
  logic [5:0] blink_mask;

  modport master (
    output tick_10ms, set_mode, sel, set_select, inc_btn, dec_btn,
    input  run_en, inc_pulse, dec_pulse, field_sel, blink_mask
  );

  modport slave (
    input  tick_10ms, set_mode, sel, set_select, inc_btn, dec_btn,
    output run_en, inc_pulse, dec_pulse, field_sel, blink_mask
  );
endinterface

// File: rtl/set_mode_ctrl.sv
// Edit-mode controller: input sync/debounce, field decode, inc/dec strobes with
// auto-repeat, run gating and field blink for the millennium clock.
module set_mode_ctrl #(
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_RATE    = 10,
  parameter int unsigned BLINK_TICKS    = 25
) (
  input logic           clk,
  input logic           rst_n,
  set_mode_ctrl_if.slave bus
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [2:0]    F_NONE  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_DELAY, S_REPEAT, S_LOCK} state_t;

  // Buttons are stored already inverted so a cleared synchronizer reads released.
  logic [1:0] sm_q, sel_q, inc_s_q, dec_s_q, vld_q;
  logic [1:0] ss0_q, ss1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_q    <= '0;
      sel_q   <= '0;
      inc_s_q <= '0;
      dec_s_q <= '0;
      vld_q   <= '0;
      ss0_q   <= '0;
      ss1_q   <= '0;
    end else begin
      sm_q    <= {sm_q[0], bus.set_mode};
      sel_q   <= {sel_q[0], bus.sel};
      inc_s_q <= {inc_s_q[0], ~bus.inc_btn};
      dec_s_q <= {dec_s_q[0], ~bus.dec_btn};
      vld_q   <= {vld_q[0], 1'b1};
      ss0_q   <= bus.set_select;
      ss1_q   <= ss0_q;
    end
  end

  function automatic logic [2:0] decode(input logic mode, input logic s, input logic [1:0] ss);
    logic [2:0] f;
    if (!mode || ss == 2'd3) f = F_NONE;
    else                     f = {1'b0, ss} + (s ? 3'd3 : 3'd0);
    return f;
  endfunction

  logic       tick;
  logic [2:0] field, field_nx;
  logic [1:0] btn_s;

  assign tick     = bus.tick_10ms;
  assign field    = decode(sm_q[1], sel_q[1], ss1_q);
  assign field_nx = decode(sm_q[0], sel_q[0], ss0_q);
  assign btn_s    = {dec_s_q[1], inc_s_q[1]};

  logic [1:0]         deb_q, deb_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    if (tick) begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (btn_s[i] == deb_q[i]) begin
          dcnt_d[i] = '0;
        end else if (dcnt_q[i] == DB_LAST) begin
          deb_d[i]  = btn_s[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q  <= '0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  state_t     state_q;
  logic       dir_q, arm_q, inc_pulse_q, dec_pulse_q, phase_q;
  logic [2:0] fld_q;
  logic [RW-1:0] rcnt_q;
  logic [BW-1:0] bcnt_q;
  logic       both, any, held, fld_ok, fire, fire_dir;

  // Strobes also require the next synced field to match, so a strobe can never
  // land in the same clk that set_mode_sync drops or the field changes.
  always_comb begin
    both     = &deb_d;
    any      = |deb_d;
    held     = deb_d[dir_q];
    fld_ok   = (field == fld_q) && (field_nx == fld_q);
    fire     = 1'b0;
    fire_dir = dir_q;
    case (state_q)
      S_IDLE: begin
        fire     = arm_q && (^deb_d) && (field != F_NONE) && (field_nx == field);
        fire_dir = deb_d[1];
      end
      S_DELAY:  fire = !both && fld_ok && held && tick && (rcnt_q == RD_LAST);
      S_REPEAT: fire = !both && fld_ok && held && tick && (rcnt_q == RR_LAST);
      default:  fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      fld_q       <= F_NONE;
      rcnt_q      <= '0;
      arm_q       <= 1'b0;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      inc_pulse_q <= fire && !fire_dir;
      dec_pulse_q <= fire && fire_dir;
      // A button held through reset must be seen released before it can act.
      if (tick && vld_q[1] && !(|btn_s)) arm_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (fire) begin
            state_q <= S_FIRST;
            dir_q   <= fire_dir;
            fld_q   <= field;
          end else if (any && (both || !arm_q || field == F_NONE)) begin
            state_q <= S_LOCK;
          end
        end
        S_FIRST, S_DELAY, S_REPEAT: begin
          if (both || !fld_ok)             state_q <= S_LOCK;
          else if (!held)                  state_q <= S_IDLE;
          else if (state_q == S_FIRST) begin
            rcnt_q  <= '0;
            state_q <= S_DELAY;
          end else if (tick) begin
            if (fire) begin
              rcnt_q  <= '0;
              state_q <= S_REPEAT;
            end else begin
              rcnt_q  <= rcnt_q + RW'(1);
            end
          end
        end
        S_LOCK:  if (!any) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (!sm_q[1] || fire) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      if (bcnt_q == BL_LAST) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q  <= bcnt_q + BW'(1);
      end
    end
  end

  assign bus.run_en     = ~sm_q[1];
  assign bus.inc_pulse  = inc_pulse_q;
  assign bus.dec_pulse  = dec_pulse_q;
  assign bus.field_sel  = field;
  assign bus.blink_mask = (phase_q && field != F_NONE) ? (6'd1 << field) : '0;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Randomized bench for set_mode_ctrl against a tick-level model of press/repeat/blink rules.
`timescale 1ns/1ps
module tb_set_mode_ctrl;
  localparam int unsigned RDELAY = 50;
  localparam int unsigned RRATE  = 10;
  localparam int unsigned BLINK  = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_mode_ctrl_if bus();

  set_mode_ctrl #(
    .DEBOUNCE_TICKS(2),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_RATE(RRATE),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, want, $time);
    end
  endtask

  typedef struct {
    int unsigned t;
    bit          d;
    int unsigned f;
  } stb_t;

  stb_t obs[$];
  stb_t exp_q[$];
  int unsigned tk = 0;
  logic prev_pulse = 1'b0;

  initial begin
    bus.tick_10ms = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      bus.tick_10ms = 1'b1;
      @(negedge clk);
      bus.tick_10ms = 1'b0;
    end
  end

  always @(posedge clk) if (bus.tick_10ms) tk <= tk + 1;

  always @(negedge clk) begin
    stb_t s;
    if (bus.inc_pulse || bus.dec_pulse) begin
      chk("excl", 32'(bus.inc_pulse & bus.dec_pulse), 0);
      chk("pulse_in_run", 32'(bus.run_en), 0);
      chk("width", 32'(prev_pulse), 0);
      s.t = tk;
      s.d = bus.dec_pulse;
      s.f = 32'(bus.field_sel);
      obs.push_back(s);
    end
    prev_pulse = bus.inc_pulse | bus.dec_pulse;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic ticks(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.tick_10ms) @(posedge clk);
    end
    #1;
  endtask

  // Strobes for a press accepted at tick a and stopped (release/lock/abort) at tick cut.
  task automatic expect_run(input int unsigned a, input int unsigned cut, input bit d, input int unsigned f);
    stb_t s;
    int unsigned t;
    s.d = d;
    s.f = f;
    if (a < cut) begin
      s.t = a;
      exp_q.push_back(s);
    end
    t = a + RDELAY;
    while (t < cut) begin
      s.t = t;
      exp_q.push_back(s);
      t += RRATE;
    end
  endtask

  task automatic compare(input string tag);
    int unsigned n;
    chk({tag, ".count"}, 32'(obs.size()), 32'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, ".tick"}, obs[i].t, exp_q[i].t);
      chk({tag, ".dir"}, 32'(obs[i].d), 32'(exp_q[i].d));
      chk({tag, ".field"}, obs[i].f, exp_q[i].f);
    end
    obs.delete();
    exp_q.delete();
  endtask

  // Pin pressed for h tick samples; a press needs two samples and is accepted at k+2.
  task automatic hold(input bit d, input int unsigned h, output int unsigned k);
    ticks(1);
    k = tk;
    if (d) bus.dec_btn = 1'b0;
    else   bus.inc_btn = 1'b0;
    ticks(h);
    bus.inc_btn = 1'b1;
    bus.dec_btn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".run_en"}, 32'(bus.run_en), 1);
    chk({tag, ".inc"}, 32'(bus.inc_pulse), 0);
    chk({tag, ".dec"}, 32'(bus.dec_pulse), 0);
    chk({tag, ".field"}, 32'(bus.field_sel), 7);
    chk({tag, ".mask"}, 32'(bus.blink_mask), 0);
  endtask

  initial begin
    int unsigned k, k2, d_tick, r, h, f;
    bit s, dd;
    logic [1:0] ss;
    bus.set_mode = 1'b0;
    bus.sel = 1'b0;
    bus.set_select = 2'd3;
    bus.inc_btn = 1'b1;
    bus.dec_btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // run mode: presses ignored
    ticks(2);
    bus.set_select = 2'd1;
    ticks(1);
    bus.inc_btn = 1'b0;
    ticks(10);
    chk("run.run_en", 32'(bus.run_en), 1);
    chk("run.field", 32'(bus.field_sel), 7);
    chk("run.mask", 32'(bus.blink_mask), 0);
    ticks(10);
    bus.inc_btn = 1'b1;
    ticks(4);
    compare("run");

    // edit MM, long hold with auto-repeat
    bus.set_mode = 1'b1;
    bus.sel = 1'b0;
    bus.set_select = 2'd1;
    @(posedge clk); #1;
    chk("edit.run_en_1clk", 32'(bus.run_en), 1);
    @(posedge clk); #1;
    chk("edit.run_en_2clk", 32'(bus.run_en), 0);
    chk("edit.field", 32'(bus.field_sel), 1);
    ticks(2);
    hold(1'b0, 97, k);
    expect_run(k + 2, k + 99, 1'b0, 1);
    ticks(4);
    compare("repeat");

    // YEAR: glitch then clean dec press
    bus.sel = 1'b1;
    bus.set_select = 2'd2;
    ticks(2);
    chk("year.field", 32'(bus.field_sel), 5);
    hold(1'b1, 1, k);
    ticks(4);
    compare("glitch");
    hold(1'b1, 5, k);
    expect_run(k + 2, k + 7, 1'b1, 5);
    ticks(4);
    compare("dec");

    // both buttons -> lock
    ticks(1);
    k = tk;
    bus.inc_btn = 1'b0;
    ticks(30);
    bus.dec_btn = 1'b0;
    ticks(10);
    bus.inc_btn = 1'b1;
    bus.dec_btn = 1'b1;
    ticks(4);
    expect_run(k + 2, k + 32, 1'b0, 5);
    compare("lock");
    hold(1'b0, 3, k);
    expect_run(k + 2, k + 5, 1'b0, 5);
    ticks(4);
    compare("after_lock");

    // blink on SS field
    bus.set_mode = 1'b0;
    bus.sel = 1'b0;
    bus.set_select = 2'd0;
    ticks(2);
    ticks(1);
    k = tk;
    bus.set_mode = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      ticks(1);
      chk("blink.idle", 32'(bus.blink_mask), (((tk - k) / BLINK) % 2) ? 1 : 0);
    end
    ticks(1);
    k = tk;
    bus.inc_btn = 1'b0;
    ticks(2);
    for (int unsigned i = 0; i < 30; i++) begin
      chk("blink.restart", 32'(bus.blink_mask), (((tk - (k + 2)) / BLINK) % 2) ? 1 : 0);
      if (i == 1) bus.inc_btn = 1'b1;
      ticks(1);
    end
    expect_run(k + 2, k + 5, 1'b0, 0);
    compare("blink_press");

    // randomized presses across fields
    for (int unsigned it = 0; it < 8; it++) begin
      s = 1'($urandom_range(0, 1));
      ss = 2'($urandom_range(0, 2));
      dd = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 70);
      f = 32'(ss) + (s ? 3 : 0);
      bus.sel = s;
      bus.set_select = ss;
      ticks(2);
      hold(dd, h, k);
      if (h >= 2) expect_run(k + 2, k + h + 2, dd, f);
      r = $urandom_range(3, 6);
      ticks(r);
      compare("rnd");
    end

    // set_mode drop mid-repeat
    bus.sel = 1'b0;
    bus.set_select = 2'd1;
    ticks(2);
    ticks(1);
    k = tk;
    bus.inc_btn = 1'b0;
    ticks(67);
    d_tick = tk;
    bus.set_mode = 1'b0;
    @(posedge clk); #1;
    chk("drop.run_en_1clk", 32'(bus.run_en), 0);
    @(posedge clk); #1;
    chk("drop.run_en_2clk", 32'(bus.run_en), 1);
    ticks(10);
    bus.inc_btn = 1'b1;
    ticks(4);
    expect_run(k + 2, d_tick + 1, 1'b0, 1);
    compare("drop");

    // reset while held
    bus.set_mode = 1'b1;
    bus.set_select = 2'd0;
    ticks(2);
    ticks(1);
    k = tk;
    bus.inc_btn = 1'b0;
    ticks(20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ticks(20);
    bus.inc_btn = 1'b1;
    ticks(5);
    expect_run(k + 2, k + 3, 1'b0, 0);
    compare("rst_hold");
    hold(1'b0, 3, k2);
    expect_run(k2 + 2, k2 + 5, 1'b0, 0);
    ticks(4);
    compare("rst_repress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
